adder_result_stage: RTL and testbench
=====================================

# adder_result_stage

Registered output stage directly downstream of the 8-bit `ADDER`. It captures the adder operands and result through a valid/ready handshake and buffers up to two results in a skid buffer. It derives carry/overflow/negative/zero flags and independently recomputes the sum to flag adder mismatches. It isolates the combinational adder from the consuming datapath stage.

## Interface
- `WIDTH`, 8, operand/result width in bits (≥2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand/result word presented
- `in_ready`  out  1  stage can accept a word this cycle
- `a`  in  WIDTH  adder operand a
- `b`  in  WIDTH  adder operand b
- `cin`  in  1  adder carry-in
- `y`  in  WIDTH  adder sum output
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  consumer accepts head entry
- `out_sum`  out  WIDTH  buffered sum (the captured `y`)
- `out_flags`  out  4  {C,V,N,Z} of head entry
- `occupancy`  out  2  entries held, 0..2
- `err_sticky`  out  1  set when any accepted `y` ≠ internal a+b+cin
- `err_clr`  in  1  synchronous clear of `err_sticky`

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- `in_ready = (occupancy != 2)`, decoded from registered state only; no combinational path from `out_ready`.
- `out_valid = (occupancy != 0)`. `out_sum`/`out_flags` always reflect the oldest entry and are stable while `out_valid && !out_ready`.
- Internal check: `{cout, chk} = a + b + cin`, computed WIDTH+1 bits wide with zero extension.
- Flags are stored per entry at push:
  - C = cout
  - V = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB])
  - N = y[MSB]
  - Z = (y==0)
- Mismatch: push with `y != chk` sets `err_sticky` next edge. `err_clr` clears it. If clear and a mismatching push occur in the same cycle, set wins.
- Occupancy transitions:
  - 0 with push: 1
  - 1 with push only: 2
  - 1 with pop only: 0
  - 1 with push and pop: 1, new entry becomes head next cycle
  - 2 with pop: 1
  - Push is impossible at 2.
- Pop at occupancy 0 is ignored (no underflow). Push at 2 cannot occur because `in_ready` is 0.
- Two storage slots with a one-bit read pointer and a one-bit write pointer. Both pointers wrap 1→0.

## Timing
- Latency: a word accepted on edge N is visible on `out_*` after edge N, with `out_valid` high in cycle N+1 when the buffer was empty.
- Throughput: one word per cycle sustained when `out_ready` is held high.
- Reset, asynchronous on `rst_n` low:
  - occupancy = 0, pointers = 0
  - `out_valid` = 0, `out_sum` = 0, `out_flags` = 0
  - `err_sticky` = 0
  - `in_ready` = 1
- Reset mid-operation discards all buffered entries. The first push after deassertion is accepted on the first rising edge with `rst_n` high.
- All outputs are registered or decoded from registers only.

## Configuration
- `ADDER_RESULT_FLAGS_EN` defined:
  - flag logic and per-entry flag storage are present
  - `out_flags` behaves as above
- `ADDER_RESULT_FLAGS_EN` undefined:
  - flag storage and flag logic are omitted
  - `out_flags` is tied to 4'b0000
  - mismatch check and `err_sticky` are unaffected

## Structure
- Package `adder_pkg`:
  - `ADDER_W` = 8
  - `flags_t` packed struct {c,v,n,z}
  - flag bit index constants
  - entry struct {sum, flags}
- Sub-module `adder_skid_buf`: the 2-entry pointer/occupancy buffer, generic in entry width.
- The top level holds the flag generation, the mismatch check and the error register.

## Test plan
- Reset, then a=8'hAA, b=8'h8A, cin=1, y=8'h35, one-cycle push, `out_ready`=1 -> next cycle `out_valid`=1, `out_sum`=8'h35, flags C=1 V=1 N=0 Z=0, `err_sticky`=0.
- Same operands with cin=0, y=8'h34 -> `out_sum`=8'h34, flags 4'b1100.
- a=8'hFF, b=8'h01, cin=0, y=8'h00 -> flags C=1 V=0 N=0 Z=1.
- a=8'hAA, b=8'h8A, cin=1, y=8'h36 -> `err_sticky`=1 next cycle and stays set until an `err_clr` pulse. With `err_clr` and a mismatching push in the same cycle, it stays 1.
- Hold `out_ready`=0, push 3 words -> after 2 pushes `in_ready`=0 and occupancy=2. Release `out_ready` -> words drain in order, with one cycle per word.
- Occupancy 1 with simultaneous push and pop -> occupancy remains 1 and the new word is at the head. Assert `rst_n`=0 with occupancy 2 -> immediately `out_valid`=0, occupancy=0, `in_ready`=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the adder result stage.
package adder_pkg;

    localparam int ADDER_W = 8;
    localparam int FLAGS_W = 4;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

    typedef struct packed {
        logic [ADDER_W-1:0] sum;
        flags_t             flags;
    } entry_t;

    // V is set when both operands share a sign that the result does not.
    function automatic flags_t make_flags(input logic cout, input logic a_msb,
                                          input logic b_msb, input logic y_msb,
                                          input logic y_zero);
        flags_t f;
        f.c = cout;
        f.v = (a_msb == b_msb) && (y_msb != a_msb);
        f.n = y_msb;
        f.z = y_zero;
        return f;
    endfunction

endpackage

// File: rtl/adder_skid_buf.sv
// Two-entry skid buffer with one-bit read/write pointers and an occupancy count.
module adder_skid_buf
    import adder_pkg::*;
#(
    parameter int ENTRY_W = ADDER_W + FLAGS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [ENTRY_W-1:0] push_data,
    output logic               pop_valid,
    input  logic               pop_ready,
    output logic [ENTRY_W-1:0] pop_data,
    output logic [1:0]         occupancy
);

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         occ_q, occ_d;
    logic               push, pop;

    assign push_ready = (occ_q != 2'd2);
    assign pop_valid  = (occ_q != 2'd0);
    assign pop_data   = mem_q[rd_ptr_q];
    assign occupancy  = occ_q;

    assign push = push_valid && push_ready;
    assign pop  = pop_valid && pop_ready;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered result stage behind the adder: buffers sums, derives flags, checks the sum.
// Define ADDER_RESULT_FLAGS_EN to build the C/V/N/Z flag logic and storage.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_flags,
    output logic [1:0]       occupancy,
    output logic             err_sticky,
    input  logic             err_clr
);

    logic [WIDTH-1:0] chk;
    logic             push;
    logic             err_q, err_d;

`ifdef ADDER_RESULT_FLAGS_EN
    localparam int ENTRY_W = WIDTH + FLAGS_W;

    logic               cout;
    flags_t             flags_in;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] pop_data;

    assign {cout, chk} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign flags_in    = make_flags(cout, a[WIDTH-1], b[WIDTH-1], y[WIDTH-1], (y == '0));
    assign push_data   = {y, flags_in};
    assign out_sum     = pop_data[ENTRY_W-1:FLAGS_W];
    assign out_flags   = pop_data[FLAGS_W-1:0];
`else
    localparam int ENTRY_W = WIDTH;

    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] pop_data;

    assign chk       = a + b + WIDTH'(cin);
    assign push_data = y;
    assign out_sum   = pop_data;
    assign out_flags = 4'b0000;
`endif

    adder_skid_buf #(
        .ENTRY_W (ENTRY_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_data),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (pop_data),
        .occupancy  (occupancy)
    );

    assign push = in_valid && in_ready;

    // A mismatching push outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (push && (y != chk)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: directed pushes queue expected entries, a monitor checks pops.
module tb_adder_result_stage;

    typedef struct {
        logic [7:0] sum;
        logic [3:0] flags;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, y;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [3:0] out_flags;
    logic [1:0] occupancy;
    logic       err_sticky;
    logic       err_clr;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    adder_result_stage #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_flags  (out_flags),
        .occupancy  (occupancy),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef ADDER_RESULT_FLAGS_EN
        return f;
`else
        return f & 4'b0000;
`endif
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [7:0] ta, input logic [7:0] tb_,
                                  input logic tcin, input logic [7:0] ty,
                                  input logic [3:0] tflags);
        logic acc;
        exp_t e;
        acc = 1'b0;
        a = ta; b = tb_; cin = tcin; y = ty;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) begin
            e.sum   = ty;
            e.flags = exp_flags(tflags);
            sb.push_back(e);
        end else begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: in_ready never rose for y=%0h", ty);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_pop: got sum %0h with empty scoreboard", out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("pop_sum", 32'(out_sum), 32'(e.sum));
                check_output("pop_flags", 32'(out_flags), 32'(e.flags));
            end
        end
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        a = '0; b = '0; y = '0; cin = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_sum", 32'(out_sum), 32'd0);
        check_output("rst_out_flags", 32'(out_flags), 32'd0);
        check_output("rst_occupancy", 32'(occupancy), 32'd0);
        check_output("rst_err", 32'(err_sticky), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        apply_stimulus(8'hAA, 8'h8A, 1'b1, 8'h35, 4'b1100);
        check_output("first_out_valid", 32'(out_valid), 32'd1);
        check_output("first_occupancy", 32'(occupancy), 32'd1);
        check_output("first_err", 32'(err_sticky), 32'd0);
        apply_stimulus(8'hAA, 8'h8A, 1'b0, 8'h34, 4'b1100);
        apply_stimulus(8'hFF, 8'h01, 1'b0, 8'h00, 4'b1001);
        check_output("good_err", 32'(err_sticky), 32'd0);

        apply_stimulus(8'hAA, 8'h8A, 1'b1, 8'h36, 4'b1100);
        check_output("mismatch_err_set", 32'(err_sticky), 32'd1);
        idle(3);
        check_output("mismatch_err_hold", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check_output("err_cleared", 32'(err_sticky), 32'd0);
        err_clr = 1'b1;
        apply_stimulus(8'hAA, 8'h8A, 1'b1, 8'h36, 4'b1100);
        err_clr = 1'b0;
        check_output("set_beats_clear", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(3);

        out_ready = 1'b0;
        apply_stimulus(8'h01, 8'h02, 1'b0, 8'h03, 4'b0000);
        apply_stimulus(8'h7F, 8'h01, 1'b0, 8'h80, 4'b0110);
        check_output("full_occupancy", 32'(occupancy), 32'd2);
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        fork
            apply_stimulus(8'h80, 8'h80, 1'b0, 8'h00, 4'b1101);
            begin
                idle(2);
                check_output("full_hold_occ", 32'(occupancy), 32'd2);
                out_ready = 1'b1;
            end
        join
        check_output("drain_occ_a", 32'(occupancy), 32'd1);
        check_output("drain_valid", 32'(out_valid), 32'd1);
        idle(1);
        check_output("drain_occ_b", 32'(occupancy), 32'd0);

        apply_stimulus(8'h10, 8'h20, 1'b0, 8'h30, 4'b0000);
        apply_stimulus(8'h0F, 8'hF0, 1'b1, 8'h00, 4'b1001);
        check_output("pushpop_occ", 32'(occupancy), 32'd1);
        check_output("pushpop_head_sum", 32'(out_sum), 32'h00);
        check_output("pushpop_head_flags", 32'(out_flags), 32'(exp_flags(4'b1001)));
        idle(1);
        check_output("pushpop_empty", 32'(occupancy), 32'd0);

        out_ready = 1'b0;
        apply_stimulus(8'h05, 8'h05, 1'b0, 8'h0A, 4'b0000);
        apply_stimulus(8'h00, 8'h00, 1'b0, 8'h00, 4'b0001);
        check_output("pre_reset_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_occupancy", 32'(occupancy), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd1);
        check_output("midrst_out_sum", 32'(out_sum), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        apply_stimulus(8'h40, 8'h40, 1'b0, 8'h80, 4'b0110);
        check_output("post_reset_occ", 32'(occupancy), 32'd1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
